// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Sequences single-byte SRAM accesses through a four-state FSM
//   (IDLE -> SETUP -> STROBE -> HOLD) and drives the SRAM strobes and
//   the two data-bus bridge enables for each access.
//
//   Parameter
//     WAIT_STATES    extra STROBE cycles per access (0..15)
//
//   Optional feature
//     MEMSEQ_BACK_TO_BACK_EN  when defined, a new request may be accepted
//                             in HOLD and the FSM goes straight to SETUP.
//
//   Ports
//     clk, rst_n             clock, asynchronous active-low reset
//     req_valid/req_ready    request handshake
//     req_write, req_addr    request kind and byte address
//     mem_addr               registered SRAM address
//     mem_ce_n/oe_n/we_n     SRAM strobes (active low)
//     d_membridge_n          MainBus->MemData bridge enable (active low)
//     a_membridge_n          MemData->MainBus bridge enable (active low)
//     mem_data               MemData bus, sampled on reads
//     rdata, rdata_valid     last read byte and its one-cycle update pulse
//     busy                   FSM not in IDLE
module mem_access_sequencer #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  output logic [15:0] mem_addr,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        d_membridge_n,
  output logic        a_membridge_n,
  input  logic [7:0]  mem_data,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state;
  logic       wr;       // direction of the access in flight
  logic [3:0] cnt;      // remaining STROBE cycles minus one
  logic       started;  // low until the first edge after reset release
  logic       accept;

  // req_ready is held low during reset and only rises once the first
  // clock edge after release has been seen.
`ifdef MEMSEQ_BACK_TO_BACK_EN
  assign req_ready = started && (state == IDLE || state == HOLD);
`else
  assign req_ready = started && (state == IDLE);
`endif

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr          <= 1'b0;
      cnt         <= 4'd0;
      mem_addr    <= 16'd0;
      rdata       <= 8'd0;
      rdata_valid <= 1'b0;
      started     <= 1'b0;
    end else begin
      started     <= 1'b1;
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SETUP;
            mem_addr <= req_addr;
            wr       <= req_write;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= WS;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
            // Read data is taken on the edge that ends the last strobe cycle.
            if (!wr) begin
              rdata       <= mem_data;
              rdata_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          // accept can only be high here when back-to-back issue is enabled.
          if (accept) begin
            state    <= SETUP;
            mem_addr <= req_addr;
            wr       <= req_write;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the registered state and direction, so
  // reset forces them inactive immediately.
  assign busy          = (state != IDLE);
  assign mem_ce_n      = (state == IDLE);
  assign mem_oe_n      = !(!wr && (state == SETUP || state == STROBE));
  assign mem_we_n      = !(wr && state == STROBE);
  assign d_membridge_n = !(wr && state != IDLE);
  assign a_membridge_n = !(!wr && state == STROBE);

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter WAIT_STATES, default 1, extra STROBE cycles per access; legal range 0..15.
REQ-002 Single clock and one reset: reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  pipeline memory request present.
REQ-006 req_ready  output  1  sequencer can accept a request this cycle.
REQ-007 req_write  input  1  1 = write (MainBus->memory), 0 = read.
REQ-008 req_addr  input  16  memory byte address.
REQ-009 mem_addr  output  16  registered address to SRAM.
REQ-010 mem_ce_n  output  1  SRAM chip enable, active low.
REQ-011 mem_oe_n  output  1  SRAM output enable, active low.
REQ-012 mem_we_n  output  1  SRAM write enable, active low.
REQ-013 d_membridge_n  output  1  memory bridge enable MainBus->MemData, active low.
REQ-014 a_membridge_n  output  1  memory bridge enable MemData->MainBus, active low.
REQ-015 mem_data  input  8  MemData bus, sampled for reads.
REQ-016 rdata  output  8  last read byte, registered.
REQ-017 rdata_valid  output  1  one-cycle pulse, rdata updated.
REQ-018 busy  output  1  high in any state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, STROBE, HOLD; all outputs SHALL be registered or decoded from state only.
REQ-020 Request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_addr/req_write SHALL be captured only then, ignored otherwise.
REQ-021 IDLE: req_ready=1; on acceptance -> SETUP, mem_addr <= req_addr.
REQ-022 SETUP (1 cycle): mem_ce_n=0; write: d_membridge_n=0; read: mem_oe_n=0; -> STROBE.
REQ-023 STROBE SHALL last exactly WAIT_STATES+1 cycles via a 4-bit down-counter; write: mem_we_n=0, d_membridge_n=0; read: mem_oe_n=0, a_membridge_n=0; -> HOLD.
REQ-024 Read: rdata SHALL capture mem_data at the edge ending the last STROBE cycle; rdata_valid=1 for exactly the HOLD cycle.
REQ-025 HOLD (1 cycle): mem_ce_n=0, mem_we_n=1, mem_oe_n=1, a_membridge_n=1; write: d_membridge_n=0 (data hold); -> IDLE.
REQ-026 Access occupancy SHALL be 3+WAIT_STATES cycles from acceptance edge to HOLD exit.
REQ-027 d_membridge_n and a_membridge_n SHALL never be low simultaneously; mem_we_n and mem_oe_n SHALL never be low simultaneously.
REQ-028 mem_addr SHALL remain stable from SETUP through HOLD; rdata SHALL hold its value between reads and SHALL not change on writes.
REQ-029 Outside SETUP/STROBE/HOLD all active-low outputs SHALL be 1.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, mem_addr=0, rdata=0, rdata_valid=0, busy=0, req_ready=0 while asserted, all active-low outputs 1, including mid-access.
REQ-031 After rst_n release, req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-032 Macro MEMSEQ_BACK_TO_BACK_EN defined: req_ready=1 also in HOLD; acceptance in HOLD -> SETUP directly (mem_ce_n stays 0), throughput one access per 3+WAIT_STATES cycles.
REQ-033 Macro undefined: req_ready=1 only in IDLE; throughput one access per 4+WAIT_STATES cycles.

Verification
REQ-034 Reset then read addr 0x1234, mem_data=0x55, WAIT_STATES=1 -> mem_addr=0x1234, mem_oe_n low 3 cycles, a_membridge_n low 2 cycles, rdata=0x55, rdata_valid one cycle in HOLD.
REQ-035 Write addr 0x00FF, WAIT_STATES=0 -> d_membridge_n low SETUP..HOLD (3 cycles), mem_we_n low exactly 1 cycle, rdata unchanged.
REQ-036 req_valid held with req_ready low, req_addr changed mid-access -> mem_addr unchanged, second request accepted only when req_ready=1.
REQ-037 rst_n asserted mid-STROBE of a write -> mem_we_n, mem_ce_n, d_membridge_n go 1 before the next clock edge, state IDLE.
REQ-038 Two consecutive reads, WAIT_STATES=2 -> acceptance edges 5 apart with MEMSEQ_BACK_TO_BACK_EN, 6 apart without; checker confirms no bridge-enable overlap all run.
